// File: rtl/dijkstra_path_reader.sv
// rtl/dijkstra_path_reader.sv - latches a destination-first path vector, validates it, streams hops source-first
module dijkstra_path_reader #(
  parameter int MAX_HOPS   = 10,
  parameter int NODE_W     = 5,
  parameter int NODE_COUNT = 19,
  parameter int TERM       = 27
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       path_valid,
  input  logic [MAX_HOPS*NODE_W-1:0] path_bus,
  output logic                       hop_valid,
  input  logic                       hop_ready,
  output logic [NODE_W-1:0]          hop_node,
  output logic [3:0]                 hop_index,
  output logic                       hop_first,
  output logic                       hop_last,
  output logic [3:0]                 path_len,
  output logic                       busy,
  output logic                       done_o,
  output logic                       err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [NODE_W-1:0] TERM_V   = NODE_W'(TERM);
  localparam logic [NODE_W-1:0] NODE_LIM = NODE_W'(NODE_COUNT);
  localparam logic [3:0]        LAST_IDX = 4'(MAX_HOPS - 1);

  logic [1:0]        state_q, state_d;
  logic              armed_q, armed_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [3:0]        len_q, len_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              load;
  logic [NODE_W-1:0] slot_q [MAX_HOPS];
  logic [NODE_W-1:0] scan_slot;
  logic [NODE_W-1:0] emit_slot;

  assign scan_slot = slot_q[idx_q];
  assign emit_slot = slot_q[ptr_q];

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    valid_d = valid_q;
    err_d   = err_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (path_valid && armed_q) begin
          load    = 1'b1;
          idx_d   = 4'd0;
          err_d   = 1'b0;
          len_d   = 4'd0;
          armed_d = 1'b0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (scan_slot == TERM_V) begin
          if (idx_q == 4'd0) begin
            err_d   = 1'b1;
            state_d = S_WAIT;
          end else begin
            len_d   = idx_q;
            ptr_d   = idx_q - 4'd1;
            state_d = S_EMIT;
          end
        end else if (scan_slot >= NODE_LIM || idx_q == LAST_IDX) begin
          err_d   = 1'b1;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_EMIT: begin
        // First EMIT cycle only raises hop_valid; beats then flow back-to-back.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (hop_ready) begin
          if (ptr_q == 4'd0) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            ptr_d = ptr_q - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (!path_valid) begin
          armed_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      idx_q   <= 4'd0;
      ptr_q   <= 4'd0;
      len_q   <= 4'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Private copy of the result: later bus changes cannot disturb a stream in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < MAX_HOPS; k++) slot_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < MAX_HOPS; k++) slot_q[k] <= path_bus[NODE_W*k +: NODE_W];
    end
  end

  assign hop_valid = valid_q;
  assign hop_node  = valid_q ? emit_slot : '0;
  assign hop_index = valid_q ? (len_q - 4'd1 - ptr_q) : 4'd0;
  assign hop_first = valid_q && (ptr_q == len_q - 4'd1);
  assign hop_last  = valid_q && (ptr_q == 4'd0);
  assign path_len  = len_q;
  assign busy      = (state_q != S_IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_dijkstra_path_reader.sv
// tb/tb_dijkstra_path_reader.sv - randomized scoreboard bench for dijkstra_path_reader
module tb_dijkstra_path_reader;

  typedef int slots_t [10];
  typedef struct {
    int node;
    int idx;
    int first;
    int last;
    int len;
  } beat_t;

  logic        clk;
  logic        reset_n;
  logic        path_valid;
  logic [49:0] path_bus;
  logic        hop_valid;
  logic        hop_ready;
  logic [4:0]  hop_node;
  logic [3:0]  hop_index;
  logic        hop_first;
  logic        hop_last;
  logic [3:0]  path_len;
  logic        busy;
  logic        done_o;
  logic        err_o;

  dijkstra_path_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .path_valid (path_valid),
    .path_bus   (path_bus),
    .hop_valid  (hop_valid),
    .hop_ready  (hop_ready),
    .hop_node   (hop_node),
    .hop_index  (hop_index),
    .hop_first  (hop_first),
    .hop_last   (hop_last),
    .path_len   (path_len),
    .busy       (busy),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  int    ready_mode = 0;
  int    stall_cnt = 0;
  int    stall_seen = 0;
  int    xfer_cnt = 0;
  int    done_cnt = 0;
  int    ok_paths = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [49:0] pack_bus(input slots_t s);
    logic [49:0] b;
    b = '0;
    for (int k = 0; k < 10; k++) b[5*k +: 5] = 5'(s[k]);
    return b;
  endfunction

  // Reference: find the first terminator, reject empty/unterminated paths and
  // any illegal id ahead of it; the route is the slots before it, reversed.
  function automatic void model(input slots_t s, output int err, output int len, output int eidx);
    int t;
    int bad;
    int lim;
    t = -1;
    bad = -1;
    for (int k = 0; k < 10; k++) if (t < 0 && s[k] == 27) t = k;
    lim = (t < 0) ? 10 : t;
    for (int j = 0; j < lim; j++) if (bad < 0 && s[j] >= 19) bad = j;
    err = 0;
    len = 0;
    eidx = 0;
    if (bad >= 0) begin
      err = 1;
      eidx = bad;
    end else if (t < 0) begin
      err = 1;
      eidx = 9;
    end else if (t == 0) begin
      err = 1;
      eidx = 0;
    end else begin
      len = t;
    end
  endfunction

  function automatic void push_beats(input slots_t s, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.node  = s[len-1-i];
      b.idx   = i;
      b.first = (i == 0) ? 1 : 0;
      b.last  = (i == len - 1) ? 1 : 0;
      b.len   = len;
      sb.push_back(b);
    end
  endfunction

  initial begin
    hop_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: hop_ready = 1'b1;
        1: hop_ready = ($urandom_range(0, 9) < 7);
        default: begin
          if (hop_valid && hop_index == 4'd1 && stall_cnt < 3) begin
            hop_ready = 1'b0;
            stall_cnt++;
          end else begin
            hop_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin : monitor
    beat_t e;
    bit    prev_stall;
    bit    prev_done;
    int    prev_node;
    int    prev_idx;
    prev_stall = 0;
    prev_done = 0;
    prev_node = 0;
    prev_idx = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 0;
        prev_done = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", int'(hop_valid), 1);
          chk("hold_node", int'(hop_node), prev_node);
          chk("hold_index", int'(hop_index), prev_idx);
        end
        if (hop_valid && hop_ready) begin
          xfer_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("hop_node", int'(hop_node), e.node);
            chk("hop_index", int'(hop_index), e.idx);
            chk("hop_first", int'(hop_first), e.first);
            chk("hop_last", int'(hop_last), e.last);
            chk("beat_path_len", int'(path_len), e.len);
          end
        end
        if (hop_valid && !hop_ready && hop_index == 4'd1) stall_seen++;
        if (done_o) begin
          done_cnt++;
          chk("done_pulse_width", int'(prev_done), 0);
        end
        prev_done  = done_o;
        prev_stall = hop_valid && !hop_ready;
        prev_node  = int'(hop_node);
        prev_idx   = int'(hop_index);
      end
    end
  end

  // Called just after a clock edge with path_valid already high and the DUT idle.
  task automatic await_result(input int e_err, input int e_len, input int e_eidx);
    int lat;
    int fin_n;
    lat = -1;
    fin_n = -1;
    @(posedge clk);
    #1;
    chk("accept_busy", int'(busy), 1);
    chk("accept_err_clear", int'(err_o), 0);
    for (int n = 1; n <= 200 && fin_n < 0; n++) begin
      @(posedge clk);
      #1;
      if (hop_valid && lat < 0) lat = n;
      if (done_o || err_o) fin_n = n;
    end
    if (fin_n < 0) begin
      chk("result_timeout", 0, 1);
    end else begin
      chk("err_o", int'(err_o), e_err);
      if (e_err != 0) begin
        chk("err_cycle", fin_n, e_eidx + 1);
        chk("err_no_beat", lat, -1);
      end else begin
        chk("first_beat_latency", lat, e_len + 2);
        chk("path_len", int'(path_len), e_len);
        chk("sb_drained_at_done", sb.size(), 0);
        ok_paths++;
      end
    end
  endtask

  task automatic release_path(input int e_err);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("wait_rel_busy", int'(busy), 1);
      chk("wait_rel_no_beat", int'(hop_valid), 0);
    end
    path_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_busy", int'(busy), 0);
    chk("err_sticky", int'(err_o), e_err);
  endtask

  task automatic run_path(input slots_t s);
    int e_err;
    int e_len;
    int e_eidx;
    model(s, e_err, e_len, e_eidx);
    if (e_err == 0) push_beats(s, e_len);
    path_bus = pack_bus(s);
    path_valid = 1'b1;
    await_result(e_err, e_len, e_eidx);
    path_bus = '1;
    release_path(e_err);
  endtask

  initial begin : stim
    slots_t s;
    int     e_err;
    int     e_len;
    int     e_eidx;
    int     base;
    int     n;
    int     len;

    reset_n = 1'b0;
    path_valid = 1'b0;
    path_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hop_valid", int'(hop_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_path_len", int'(path_len), 0);
    chk("rst_hop_node", int'(hop_node), 0);
    chk("rst_hop_flags", int'({hop_first, hop_last, hop_index}), 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    ready_mode = 0;
    s = '{0, 27, 27, 27, 27, 27, 27, 27, 27, 27};
    run_path(s);

    s = '{13, 10, 3, 0, 27, 27, 27, 27, 27, 27};
    run_path(s);

    ready_mode = 2;
    stall_cnt = 0;
    stall_seen = 0;
    run_path(s);
    chk("stall_cycles_at_beat1", stall_seen, 3);

    ready_mode = 0;
    s = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
    run_path(s);

    s = '{13, 20, 0, 27, 27, 27, 27, 27, 27, 27};
    run_path(s);
    s = '{13, 10, 3, 0, 27, 27, 27, 27, 27, 27};
    run_path(s);

    // Reset in the middle of a stream, then re-accept the still-valid result.
    s = '{4, 9, 14, 2, 7, 27, 27, 27, 27, 27};
    model(s, e_err, e_len, e_eidx);
    push_beats(s, e_len);
    path_bus = pack_bus(s);
    path_valid = 1'b1;
    @(posedge clk);
    base = xfer_cnt;
    n = 0;
    while (xfer_cnt < base + 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("pre_reset_hop_valid", int'(hop_valid), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_hop_valid", int'(hop_valid), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_path_len", int'(path_len), 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push_beats(s, e_len);
    await_result(e_err, e_len, e_eidx);
    release_path(e_err);

    ready_mode = 1;
    for (int iter = 0; iter < 40; iter++) begin
      if ($urandom_range(0, 3) != 0) begin
        len = $urandom_range(1, 9);
        for (int k = 0; k < 10; k++) begin
          if (k < len) s[k] = $urandom_range(0, 18);
          else if (k == len) s[k] = 27;
          else s[k] = $urandom_range(0, 31);
        end
      end else begin
        for (int k = 0; k < 10; k++) s[k] = $urandom_range(0, 31);
      end
      run_path(s);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, ok_paths);
    chk("sb_empty_at_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
